// File: rtl/fetch_stage.sv
// Instruction fetch for the 5-stage RV32 core: PC generation, imem request handshake
// and the IF/ID pipeline register, with load-use stall and EX redirect handling.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
  logic [31:0] if_id_inst_q, if_id_inst_d;
  logic        if_id_valid_q, if_id_valid_d;

  logic [31:0] target_pc;
  logic [31:0] pc_plus4;

  assign target_pc = {redirect_pc[31:2], 2'b00};
  assign pc_plus4  = pc_q + 32'd4;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirect outranks stall everywhere
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          state_d = imem_ready ? FETCH : DRAIN;
        end else if (imem_ready && stall) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid || !stall) begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (imem_ready) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Outputs; no request may leave while reset is held
  always_comb begin
    imem_req  = !rst && (state_q != HOLD);
    imem_addr = pc_q;
  end

  always_comb begin
    pc_d             = pc_q;
    pending_pc_d     = pending_pc_q;
    hold_pc_d        = hold_pc_q;
    hold_inst_d      = hold_inst_q;
    if_id_pc_d       = if_id_pc_q;
    if_id_pc_plus4_d = if_id_pc_plus4_q;
    if_id_inst_d     = if_id_inst_q;
    if_id_valid_d    = if_id_valid_q;
    case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          if_id_valid_d = 1'b0;
          if_id_inst_d  = NOP_INST;
          if (imem_ready) pc_d = target_pc;
          else            pending_pc_d = target_pc;
        end else if (imem_ready) begin
          pc_d = pc_plus4;
          if (stall) begin
            hold_pc_d   = pc_q;
            hold_inst_d = imem_rdata;
          end else begin
            if_id_pc_d       = pc_q;
            if_id_pc_plus4_d = pc_plus4;
            if_id_inst_d     = imem_rdata;
            if_id_valid_d    = 1'b1;
          end
        end else if (!stall) begin
          // Decode consumed the slot but nothing arrived: insert a bubble
          if_id_valid_d = 1'b0;
          if_id_inst_d  = NOP_INST;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          if_id_valid_d = 1'b0;
          if_id_inst_d  = NOP_INST;
          pc_d          = target_pc;
        end else if (!stall) begin
          if_id_pc_d       = hold_pc_q;
          if_id_pc_plus4_d = hold_pc_q + 32'd4;
          if_id_inst_d     = hold_inst_q;
          if_id_valid_d    = 1'b1;
        end
      end
      DRAIN: begin
        if_id_valid_d = 1'b0;
        if_id_inst_d  = NOP_INST;
        if (redirect_valid) begin
          if (imem_ready) pc_d = target_pc;
          else            pending_pc_d = target_pc;
        end else if (imem_ready) begin
          pc_d = pending_pc_q;
        end
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q             <= RESET_PC;
      pending_pc_q     <= '0;
      hold_pc_q        <= '0;
      hold_inst_q      <= '0;
      if_id_pc_q       <= '0;
      if_id_pc_plus4_q <= '0;
      if_id_inst_q     <= NOP_INST;
      if_id_valid_q    <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      pending_pc_q     <= pending_pc_d;
      hold_pc_q        <= hold_pc_d;
      hold_inst_q      <= hold_inst_d;
      if_id_pc_q       <= if_id_pc_d;
      if_id_pc_plus4_q <= if_id_pc_plus4_d;
      if_id_inst_q     <= if_id_inst_d;
      if_id_valid_q    <= if_id_valid_d;
    end
  end

  assign if_id_pc       = if_id_pc_q;
  assign if_id_pc_plus4 = if_id_pc_plus4_q;
  assign if_id_inst     = if_id_inst_q;
  assign if_id_valid    = if_id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, reset/wrap sequences, then random
// traffic checked against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] if_id_pc, if_id_pc_plus4, if_id_inst;
  logic        if_id_valid;

  logic        rst2 = 1'b1;
  logic        req2;
  logic [31:0] addr2, pc2, pc4_2, inst2;
  logic        valid2;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .if_id_pc(if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_inst(if_id_inst), .if_id_valid(if_id_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst2), .stall(1'b0), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .imem_req(req2), .imem_addr(addr2),
    .imem_ready(1'b1), .imem_rdata(32'h1234_5678), .if_id_pc(pc2),
    .if_id_pc_plus4(pc4_2), .if_id_inst(inst2), .if_id_valid(valid2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] inst_for(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp, input logic rd,
                              input logic eq, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep);
    vec_t v;
    v.stall = s; v.redir = r; v.rpc = rp; v.ready = rd;
    v.exp_req = eq; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
    return v;
  endfunction

  // Behavioural model: fetch address, a one-entry buffer for a fetch taken during stall,
  // a pending redirect target while an old request drains, and the IF/ID slot.
  logic [31:0] m_pc, m_buf_pc, m_buf_inst, m_pending, m_ifpc, m_ifinst;
  logic        m_buf, m_drain, m_v;

  task automatic model_reset(input logic [31:0] rpc0);
    m_pc = rpc0; m_buf = 0; m_drain = 0; m_v = 0; m_ifpc = 0; m_ifinst = NOP;
    m_buf_pc = 0; m_buf_inst = 0; m_pending = 0;
  endtask

  task automatic model_step(input logic s, input logic r, input logic [31:0] rp,
                            input logic rd, input logic [31:0] data);
    logic [31:0] tgt;
    tgt = rp & 32'hFFFF_FFFC;
    if (r) begin
      m_v = 0; m_ifinst = NOP;
      if (m_buf) begin
        m_buf = 0; m_pc = tgt;
      end else if (rd) begin
        m_drain = 0; m_pc = tgt;
      end else begin
        m_drain = 1; m_pending = tgt;
      end
    end else if (m_drain) begin
      if (rd) begin m_pc = m_pending; m_drain = 0; end
    end else if (m_buf) begin
      if (!s) begin
        m_buf = 0; m_v = 1; m_ifpc = m_buf_pc; m_ifinst = m_buf_inst;
      end
    end else if (rd) begin
      if (s) begin
        m_buf = 1; m_buf_pc = m_pc; m_buf_inst = data;
      end else begin
        m_v = 1; m_ifpc = m_pc; m_ifinst = data;
      end
      m_pc = m_pc + 4;
    end else if (!s) begin
      m_v = 0; m_ifinst = NOP;
    end
  endtask

  task automatic check_ifid(input string tag, input logic ev, input logic [31:0] ep,
                            input logic [31:0] ei);
    check({tag, " valid"}, {31'b0, if_id_valid}, {31'b0, ev});
    check({tag, " inst"}, if_id_inst, ei);
    if (ev) begin
      check({tag, " pc"}, if_id_pc, ep);
      check({tag, " pc_plus4"}, if_id_pc_plus4, ep + 32'd4);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = mk(0, 0, 0,      1, 1, 32'h000, 1, 32'h000);
    vecs[1]  = mk(0, 0, 0,      1, 1, 32'h004, 1, 32'h004);
    vecs[2]  = mk(0, 0, 0,      1, 1, 32'h008, 1, 32'h008);
    vecs[3]  = mk(1, 0, 0,      1, 1, 32'h00C, 1, 32'h008);
    vecs[4]  = mk(1, 0, 0,      1, 0, 32'h010, 1, 32'h008);
    vecs[5]  = mk(0, 0, 0,      1, 0, 32'h010, 1, 32'h00C);
    vecs[6]  = mk(1, 1, 32'h103,1, 1, 32'h010, 0, 32'h0);
    vecs[7]  = mk(0, 0, 0,      1, 1, 32'h100, 1, 32'h100);
    vecs[8]  = mk(0, 1, 32'h40, 0, 1, 32'h104, 0, 32'h0);
    vecs[9]  = mk(0, 0, 0,      0, 1, 32'h104, 0, 32'h0);
    vecs[10] = mk(0, 0, 0,      1, 1, 32'h104, 0, 32'h0);
    vecs[11] = mk(0, 0, 0,      1, 1, 32'h040, 1, 32'h040);
    vecs[12] = mk(0, 1, 32'h80, 0, 1, 32'h044, 0, 32'h0);
    vecs[13] = mk(0, 1, 32'h92, 0, 1, 32'h044, 0, 32'h0);
    vecs[14] = mk(0, 0, 0,      1, 1, 32'h044, 0, 32'h0);
    vecs[15] = mk(0, 0, 0,      1, 1, 32'h090, 1, 32'h090);

    repeat (2) @(negedge clk);
    check("reset req", {31'b0, imem_req}, 32'd0);
    check("reset addr", imem_addr, 32'h0);
    check("reset valid", {31'b0, if_id_valid}, 32'd0);
    check("reset inst", if_id_inst, NOP);
    check("reset pc", if_id_pc, 32'h0);
    check("reset pc_plus4", if_id_pc_plus4, 32'h0);
    rst = 1'b0;
    rst2 = 1'b0;

    for (int i = 0; i < 16; i++) begin
      stall          = vecs[i].stall;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      imem_ready     = vecs[i].ready;
      imem_rdata     = inst_for(vecs[i].exp_addr);
      #1;
      check($sformatf("vec%0d req", i), {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
      check($sformatf("vec%0d addr", i), imem_addr, vecs[i].exp_addr);
      if (i < 3) check($sformatf("wrap addr%0d", i), addr2, 32'hFFFF_FFF8 + 32'(4 * i));
      @(posedge clk); #1;
      check_ifid($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc,
                 vecs[i].exp_valid ? inst_for(vecs[i].exp_pc) : NOP);
      if (i == 1) begin
        check("wrap pc", pc2, 32'hFFFF_FFFC);
        check("wrap pc_plus4", pc4_2, 32'h0);
      end
      $display("vec%0d: addr=%08h req=%0b if_id valid=%0b pc=%08h inst=%08h",
               i, imem_addr, imem_req, if_id_valid, if_id_pc, if_id_inst);
      @(negedge clk);
    end

    // Reset asserted while a stalled fetch sits in the hold buffer
    stall = 1; redirect_valid = 0; imem_ready = 1; imem_rdata = inst_for(32'h94);
    @(posedge clk); #1;
    check("hold entry valid", {31'b0, if_id_valid}, 32'd1);
    check("hold entry pc", if_id_pc, 32'h90);
    @(negedge clk); #1;
    check("hold req", {31'b0, imem_req}, 32'd0);
    rst = 1'b1;
    #1;
    check("async rst valid", {31'b0, if_id_valid}, 32'd0);
    check("async rst inst", if_id_inst, NOP);
    check("async rst pc", if_id_pc, 32'h0);
    check("async rst req", {31'b0, imem_req}, 32'd0);
    check("async rst addr", imem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0; stall = 0; imem_ready = 1;
    for (int i = 0; i < 2; i++) begin
      imem_rdata = inst_for(32'(4 * i));
      #1;
      check($sformatf("post-rst addr%0d", i), imem_addr, 32'(4 * i));
      @(posedge clk); #1;
      check_ifid($sformatf("post-rst%0d", i), 1'b1, 32'(4 * i), inst_for(32'(4 * i)));
      $display("post-rst%0d: if_id valid=%0b pc=%08h", i, if_id_valid, if_id_pc);
      @(negedge clk);
    end

    // Random traffic against the model
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset(32'h0);
    for (int c = 0; c < 400; c++) begin
      stall          = ($urandom_range(0, 99) < 30);
      redirect_valid = ($urandom_range(0, 99) < 10);
      redirect_pc    = $urandom;
      imem_ready     = ($urandom_range(0, 99) < 70);
      imem_rdata     = $urandom;
      #1;
      check($sformatf("rnd%0d req", c), {31'b0, imem_req}, {31'b0, !m_buf});
      check($sformatf("rnd%0d addr", c), imem_addr, m_pc);
      model_step(stall, redirect_valid, redirect_pc, imem_ready, imem_rdata);
      @(posedge clk); #1;
      check_ifid($sformatf("rnd%0d", c), m_v, m_ifpc, m_ifinst);
      $display("rnd%0d: st=%0b rd=%0b rdy=%0b addr=%08h valid=%0b pc=%08h",
               c, stall, redirect_valid, imem_ready, imem_addr, if_id_valid, if_id_pc);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
